// File: rtl/layer_addr_gen.sv
// Four-lane sprite ROM address generator with double-buffered sprite tables.
// Two-stage pipeline: hit test and offset in S1, base add / transparency select in S2.
module layer_addr_gen #(
   parameter int          SPR_W            = 32,
   parameter int          SPR_H            = 32,
   parameter logic [16:0] TRANSPARENT_ADDR = 17'h0
) (
   input  logic        clk_25MHz,
   input  logic        rst_n,
   input  logic [9:0]  h_cnt,
   input  logic [9:0]  v_cnt,
   input  logic        frame_start,
   input  logic        wr_valid,
   output logic        wr_ready,
   input  logic [1:0]  wr_idx,
   input  logic        wr_en,
   input  logic [9:0]  wr_x,
   input  logic [9:0]  wr_y,
   input  logic [16:0] wr_base,
   output logic [67:0] addr,
   output logic        addr_valid,
   output logic [3:0]  active_en
);

   localparam int SH = $clog2(SPR_W);

   logic [3:0]        pend_en_q,   pend_en_d;
   logic [3:0][9:0]   pend_x_q,    pend_x_d;
   logic [3:0][9:0]   pend_y_q,    pend_y_d;
   logic [3:0][16:0]  pend_base_q, pend_base_d;
   logic [3:0]        act_en_q,    act_en_d;
   logic [3:0][9:0]   act_x_q,     act_x_d;
   logic [3:0][9:0]   act_y_q,     act_y_d;
   logic [3:0][16:0]  act_base_q,  act_base_d;

   logic [3:0]        hit_q,  hit_d;
   logic [3:0][16:0]  base_q, base_d;
   logic [3:0][16:0]  off_q,  off_d;
   logic [3:0][16:0]  addr_q, addr_d;
   logic [1:0]        vld_q,  vld_d;
   logic              rdy_q,  rdy_d;

   logic [3:0][10:0]  rel_x, rel_y;

   assign wr_ready   = rdy_q & ~frame_start;
   assign addr       = addr_q;
   assign addr_valid = vld_q[1];
   assign active_en  = act_en_q;

   always_comb begin
      pend_en_d   = pend_en_q;
      pend_x_d    = pend_x_q;
      pend_y_d    = pend_y_q;
      pend_base_d = pend_base_q;
      act_en_d    = act_en_q;
      act_x_d     = act_x_q;
      act_y_d     = act_y_q;
      act_base_d  = act_base_q;
      if (wr_valid && wr_ready) begin
         pend_en_d[wr_idx]   = wr_en;
         pend_x_d[wr_idx]    = wr_x;
         pend_y_d[wr_idx]    = wr_y;
         pend_base_d[wr_idx] = wr_base;
      end
      // Commit copies the table as it stood before this edge; a write cannot coincide.
      if (frame_start) begin
         act_en_d   = pend_en_q;
         act_x_d    = pend_x_q;
         act_y_d    = pend_y_q;
         act_base_d = pend_base_q;
      end
   end

   always_comb begin
      rel_x  = '0;
      rel_y  = '0;
      hit_d  = '0;
      base_d = '0;
      off_d  = '0;
      addr_d = '0;
      for (int i = 0; i < 4; i++) begin
         rel_x[i]  = {1'b0, h_cnt} - {1'b0, act_x_q[i]};
         rel_y[i]  = {1'b0, v_cnt} - {1'b0, act_y_q[i]};
         hit_d[i]  = act_en_q[i] & ~rel_x[i][10] & ~rel_y[i][10]
                     & (rel_x[i] < 11'(SPR_W)) & (rel_y[i] < 11'(SPR_H));
         // Base is carried with the pixel so a commit between stages cannot mix frames.
         base_d[i] = act_base_q[i];
         off_d[i]  = (17'(rel_y[i][9:0]) << SH) + 17'(rel_x[i][9:0]);
         addr_d[i] = hit_q[i] ? base_q[i] + off_q[i] : TRANSPARENT_ADDR;
      end
      vld_d = {vld_q[0], 1'b1};
      rdy_d = 1'b1;
   end

   always_ff @(posedge clk_25MHz or negedge rst_n) begin
      if (!rst_n) begin
         pend_en_q   <= '0;
         pend_x_q    <= '0;
         pend_y_q    <= '0;
         pend_base_q <= '0;
         act_en_q    <= '0;
         act_x_q     <= '0;
         act_y_q     <= '0;
         act_base_q  <= '0;
         hit_q       <= '0;
         base_q      <= '0;
         off_q       <= '0;
         addr_q      <= {4{TRANSPARENT_ADDR}};
         vld_q       <= '0;
         rdy_q       <= 1'b0;
      end else begin
         pend_en_q   <= pend_en_d;
         pend_x_q    <= pend_x_d;
         pend_y_q    <= pend_y_d;
         pend_base_q <= pend_base_d;
         act_en_q    <= act_en_d;
         act_x_q     <= act_x_d;
         act_y_q     <= act_y_d;
         act_base_q  <= act_base_d;
         hit_q       <= hit_d;
         base_q      <= base_d;
         off_q       <= off_d;
         addr_q      <= addr_d;
         vld_q       <= vld_d;
         rdy_q       <= rdy_d;
      end
   end

endmodule

// File: tb/tb_layer_addr_gen.sv
// Directed bench for layer_addr_gen: vector table for single-sprite coverage
// plus hand sequences for commit timing, handshake, wrap and reset.
module tb_layer_addr_gen;

   logic        clk_25MHz = 1'b0;
   logic        rst_n;
   logic [9:0]  h_cnt, v_cnt;
   logic        frame_start, wr_valid, wr_ready, wr_en;
   logic [1:0]  wr_idx;
   logic [9:0]  wr_x, wr_y;
   logic [16:0] wr_base;
   logic [67:0] addr;
   logic        addr_valid;
   logic [3:0]  active_en;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [9:0]  h;
      logic [9:0]  v;
      logic [67:0] exp;
   } vec_t;
   vec_t vt[8];

   layer_addr_gen dut (
      .clk_25MHz(clk_25MHz), .rst_n(rst_n), .h_cnt(h_cnt), .v_cnt(v_cnt),
      .frame_start(frame_start), .wr_valid(wr_valid), .wr_ready(wr_ready),
      .wr_idx(wr_idx), .wr_en(wr_en), .wr_x(wr_x), .wr_y(wr_y),
      .wr_base(wr_base), .addr(addr), .addr_valid(addr_valid),
      .active_en(active_en)
   );

   always #20 clk_25MHz = ~clk_25MHz;

   task automatic tick();
      @(posedge clk_25MHz);
      #1;
   endtask

   task automatic chk(input string name, input logic [67:0] act, input logic [67:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual %h required %h", name, act, exp);
      end
   endtask

   task automatic wr(input logic [1:0] idx, input logic en, input logic [9:0] x,
                     input logic [9:0] y, input logic [16:0] base);
      wr_valid = 1'b1; wr_idx = idx; wr_en = en; wr_x = x; wr_y = y; wr_base = base;
      tick();
      wr_valid = 1'b0;
   endtask

   task automatic commit();
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
   endtask

   task automatic pix(input logic [9:0] h, input logic [9:0] v);
      h_cnt = h; v_cnt = v;
      tick();
      tick();
   endtask

   initial begin
      // sprite 0 at (100,50), base 1024, SPR_W=SPR_H=32
      vt[0] = '{10'd105, 10'd52, 68'd1093};
      vt[1] = '{10'd99,  10'd50, 68'd0};
      vt[2] = '{10'd100, 10'd50, 68'd1024};
      vt[3] = '{10'd131, 10'd50, 68'd1055};
      vt[4] = '{10'd132, 10'd50, 68'd0};
      vt[5] = '{10'd110, 10'd82, 68'd0};
      vt[6] = '{10'd110, 10'd81, 68'd2026};
      vt[7] = '{10'd100, 10'd49, 68'd0};

      rst_n = 1'b0; h_cnt = '0; v_cnt = '0; frame_start = 1'b0; wr_valid = 1'b0;
      wr_idx = '0; wr_en = 1'b0; wr_x = '0; wr_y = '0; wr_base = '0;
      tick(); tick();
      chk("rst_addr", addr, 68'h0);
      chk("rst_valid", 68'(addr_valid), 68'd0);
      chk("rst_active_en", 68'(active_en), 68'd0);
      rst_n = 1'b1;
      tick();
      chk("valid_after_1", 68'(addr_valid), 68'd0);
      chk("ready_after_1", 68'(wr_ready), 68'd1);
      tick();
      chk("valid_after_2", 68'(addr_valid), 68'd1);

      wr(2'd0, 1'b1, 10'd100, 10'd50, 17'd1024);
      pix(10'd105, 10'd52);
      chk("no_commit_yet", addr, 68'h0);
      commit();
      chk("active_en_0", 68'(active_en), 68'h1);
      for (int i = 0; i < 8; i++) begin
         pix(vt[i].h, vt[i].v);
         chk($sformatf("vec%0d", i), addr, vt[i].exp);
      end

      wr(2'd0, 1'b1, 10'd200, 10'd50, 17'd1024);
      pix(10'd105, 10'd52);
      chk("pending_hidden", addr, 68'd1093);
      frame_start = 1'b1;
      wr_valid = 1'b1; wr_idx = 2'd0; wr_en = 1'b1; wr_x = 10'd90; wr_y = 10'd50; wr_base = 17'd1024;
      #1;
      chk("ready_low_in_commit", 68'(wr_ready), 68'd0);
      tick();
      frame_start = 1'b0;
      #1;
      chk("ready_retry", 68'(wr_ready), 68'd1);
      tick();
      wr_valid = 1'b0;
      pix(10'd105, 10'd52);
      chk("committed_x200_miss", addr, 68'd0);
      pix(10'd205, 10'd52);
      chk("committed_x200_hit", addr, 68'd1093);
      commit();
      pix(10'd105, 10'd52);
      chk("retried_x90", addr, 68'd1103);

      wr(2'd1, 1'b1, 10'd700, 10'd0, 17'h1FFF0);
      commit();
      pix(10'd5, 10'd0);
      chk("neg_rel_x", addr, 68'd0);
      pix(10'd700, 10'd1);
      chk("wrap", addr, {17'd0, 17'd0, 17'h00010, 17'd0});

      wr(2'd0, 1'b1, 10'd20, 10'd0, 17'h1000);
      wr(2'd1, 1'b1, 10'd15, 10'd0, 17'h2000);
      wr(2'd2, 1'b1, 10'd10, 10'd0, 17'h0100);
      wr(2'd2, 1'b1, 10'd20, 10'd0, 17'h0100);
      wr(2'd3, 1'b1, 10'd0,  10'd0, 17'h0300);
      commit();
      chk("active_en_all", 68'(active_en), 68'hF);
      pix(10'd25, 10'd3);
      chk("four_lanes", addr, {17'h0379, 17'h0165, 17'h206A, 17'h1065});

      #5;
      rst_n = 1'b0;
      #1;
      chk("midrst_addr", addr, 68'h0);
      chk("midrst_valid", 68'(addr_valid), 68'd0);
      chk("midrst_active_en", 68'(active_en), 68'd0);
      tick();
      rst_n = 1'b1;
      tick();
      chk("midrst_valid_1", 68'(addr_valid), 68'd0);
      tick();
      chk("midrst_valid_2", 68'(addr_valid), 68'd1);
      pix(10'd25, 10'd3);
      chk("midrst_transparent", addr, 68'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
